// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit scheduler state type.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } tx_sched_state_t;

  localparam int unsigned TX_BUSY_TIMEOUT = 4;
  localparam int unsigned UART_DATA_W     = 8;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, searched cyclically.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  // Scan from the farthest offset back to ptr so the nearest requester is written last.
  always_comb begin
    int unsigned j;
    j   = 0;
    gnt = '0;
    idx = '0;
    for (int unsigned k = N; k > 0; k--) begin
      j = (32'(ptr) + k - 1) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NREQ registered-read byte FIFOs:
// pop -> load -> start -> wait for busy -> gap, so each byte is sent exactly once.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned DATA_W     = UART_DATA_W,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NREQ-1:0]          src_empty,
  output logic [NREQ-1:0]          src_rd,
  input  logic [NREQ*DATA_W-1:0]   src_data,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     active,
  output logic [15:0]              sent_cnt
);

  localparam int unsigned ID_W = $clog2(NREQ);
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  // The busy-wait window includes the START cycle, so WAIT_BUSY gives up one count early.
  localparam logic [15:0] TMO_LAST = 16'(TX_BUSY_TIMEOUT - 2);
  localparam tx_sched_state_t BYTE_DONE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  tx_sched_state_t state_q, state_d;
  logic [15:0]     cnt_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] req;
  logic            grant_go;

  assign req      = ~src_empty;
  assign active   = (state_q != S_IDLE);
  assign grant_go = (state_q == S_IDLE) && (state_d == S_POP);

  rr_pick #(
    .N     (NREQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (en && (|req)) state_d = S_POP;
      S_POP:       state_d = S_LOAD;
      S_LOAD:      state_d = S_START;
      S_START:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy)                state_d = S_WAIT_DONE;
        else if (cnt_q == TMO_LAST) state_d = BYTE_DONE;
      end
      S_WAIT_DONE: if (!tx_busy) state_d = BYTE_DONE;
      S_GAP:       if (cnt_q == GAP_LAST) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      src_rd   <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      sent_cnt <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
      src_rd   <= grant_go ? pick_gnt : '0;
      tx_start <= (state_d == S_START);
      if (grant_go) begin
        grant_id <= pick_idx;
        rr_ptr_q <= (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      // FIFO data is valid in LOAD; the count steps on the same edge tx_start rises.
      if (state_q == S_LOAD) begin
        tx_data  <= src_data[grant_id*DATA_W +: DATA_W];
        sent_cnt <= sent_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: FIFO and uart_tx busy models plus a
// queue-based round-robin reference that predicts byte order, owner and timing.
module tb_uart_tx_sched;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned GAP    = 16;
  localparam int unsigned ID_W   = $clog2(NREQ);
  localparam int unsigned DW_ALL = NREQ * DATA_W;
  localparam int          NQ     = 2;
  localparam int          G      = 16;
  localparam int          NEVER  = 32'h3fff_ffff;

  logic                 clk       = 1'b0;
  logic                 rst       = 1'b1;
  logic                 en        = 1'b0;
  logic [NREQ-1:0]      src_empty = '1;
  logic [NREQ-1:0]      src_rd;
  logic [DW_ALL-1:0]    src_data  = '0;
  logic                 tx_start;
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_busy   = 1'b0;
  logic [ID_W-1:0]      grant_id;
  logic                 active;
  logic [15:0]          sent_cnt;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NREQ       (NREQ),
    .DATA_W     (DATA_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .src_empty (src_empty),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .sent_cnt  (sent_cnt)
  );

  int unsigned       n_vec = 0;
  int unsigned       n_err = 0;
  int                cyc   = 0;
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  int                m_ptr     = 0;
  logic [15:0]       m_sent    = '0;
  int                exp_src   = -1;
  logic [DATA_W-1:0] exp_byte  = '0;
  logic [DATA_W-1:0] last_byte = '0;
  int                t_pop     = 0;
  int                idle_from = 0;
  int                en_from   = 0;
  int                pend_pop  = -1;
  int                busy_left = 0;
  int                frame_fix = -1;
  int                n_pops    = 0;
  bit                inflight  = 1'b0;
  bit                busy_hi   = 1'b0;
  bit                en_prev   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int q_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [DATA_W-1:0] q_front(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic [DATA_W-1:0] q_pop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic q_push(input int i, input logic [DATA_W-1:0] v);
    if (i == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  // Reference arbiter: first non-empty queue at or after the model pointer.
  function automatic int pick_model();
    for (int k = 0; k < NQ; k++) begin
      int j;
      j = (m_ptr + k) % NQ;
      if (q_size(j) > 0) return j;
    end
    return -1;
  endfunction

  function automatic bit quiet();
    return !inflight && !busy_hi && (q0.size() == 0) && (q1.size() == 0) &&
           (pend_pop < 0) && (cyc > idle_from + 1) && !active;
  endfunction

  // Environment + reference model: FIFOs and uart_tx driven after each rising edge,
  // DUT observed on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      src_data = DW_ALL'($urandom);
      if (pend_pop >= 0) begin
        src_data[pend_pop*DATA_W +: DATA_W] = q_pop(pend_pop);
        pend_pop = -1;
      end
      src_empty[0] = (q0.size() == 0);
      src_empty[1] = (q1.size() == 0);
      if (busy_left > 0) begin
        tx_busy = 1'b1;
        busy_left--;
        busy_hi = 1'b1;
      end else begin
        tx_busy = 1'b0;
        if (busy_hi) begin
          busy_hi   = 1'b0;
          inflight  = 1'b0;
          idle_from = cyc + 1 + G;   // low is seen on the next edge, then GAP
        end
      end

      @(negedge clk);
      if (!rst) begin
        m_ptr     = 0;
        m_sent    = '0;
        inflight  = 1'b0;
        busy_left = 0;
        busy_hi   = 1'b0;
        pend_pop  = -1;
        last_byte = '0;
        idle_from = cyc + 1;
      end else begin
        if (en && !en_prev) en_from = cyc;
        if (src_rd != '0) begin
          int exp_pop;
          n_pops++;
          exp_src = pick_model();
          exp_pop = (en_prev && exp_src >= 0) ?
                    (((idle_from > en_from) ? idle_from : en_from) + 1) : NEVER;
          check_eq("pop_cycle", 32'(cyc), 32'(exp_pop));
          check_eq("src_rd", 32'(src_rd), (exp_src >= 0) ? (32'd1 << exp_src) : 32'd0);
          check_eq("tx_data_hold", 32'(tx_data), 32'(last_byte));
          if (exp_src >= 0) begin
            exp_byte = q_front(exp_src);
            pend_pop = exp_src;
            m_ptr    = (exp_src + 1) % NQ;
          end
          t_pop    = cyc;
          inflight = 1'b1;
        end
        if (tx_start) begin
          int f;
          m_sent++;
          check_eq("start_cycle", 32'(cyc), 32'(t_pop + 2));
          check_eq("tx_data", 32'(tx_data), 32'(exp_byte));
          check_eq("grant_id", 32'(grant_id), 32'(exp_src));
          check_eq("sent_cnt", 32'(sent_cnt), 32'(m_sent));
          check_eq("active", 32'(active), 32'd1);
          last_byte = exp_byte;
          if (frame_fix >= 0)                 f = frame_fix;
          else if ($urandom_range(0, 4) == 0) f = 0;
          else                                f = int'($urandom_range(1, 30));
          if (f == 0) begin
            inflight  = 1'b0;
            idle_from = cyc + 4 + G;   // timeout: GAP entered 4 cycles after tx_start
          end else begin
            busy_left = f;
          end
        end
      end
      en_prev = en;
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 80000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic kick();
    step(1);
    en = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!quiet() && n < budget) begin
      step(1);
      n++;
    end
    check_eq("drain", 32'(quiet()), 32'd1);
  endtask

  task automatic wait_sig(input string tag, input bit on_start, input int budget);
    int n;
    bit hit;
    n   = 0;
    hit = on_start ? tx_start : tx_busy;
    while (!hit && n < budget) begin
      step(1);
      n++;
      hit = on_start ? tx_start : tx_busy;
    end
    check_eq(tag, 32'(hit), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_src_rd"},   32'(src_rd),   32'd0);
    check_eq({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check_eq({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check_eq({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check_eq({tag, "_active"},   32'(active),   32'd0);
    check_eq({tag, "_sent_cnt"}, 32'(sent_cnt), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    int snap;
    #1 rst = 1'b0;
    step(2);
    check_reset_outputs("por");
    rst = 1'b1;
    step(2);

    // Single byte with a 100-cycle frame.
    en = 1'b0;
    frame_fix = 100;
    q_push(0, 8'hA5);
    kick();
    drain(2000);
    check_eq("single_sent_cnt", 32'(sent_cnt), 32'd1);

    // Round-robin between two loaded sources from a fresh pointer.
    en = 1'b0;
    pulse_reset();
    frame_fix = 20;
    for (int i = 0; i < 3; i++) begin
      q_push(0, 8'(8'h10 + i));
      q_push(1, 8'(8'h20 + i));
    end
    kick();
    drain(3000);

    // Enable dropped while a byte is on the line.
    en = 1'b0;
    frame_fix = 40;
    q_push(0, 8'h51);
    q_push(0, 8'h52);
    q_push(1, 8'h61);
    kick();
    wait_sig("en_drop_busy", 1'b0, 200);
    en = 1'b0;
    snap = n_pops;
    for (int n = 0; n < 400 && (inflight || cyc <= idle_from + 20); n++) step(1);
    check_eq("en_low_no_pop", 32'(n_pops), 32'(snap));
    check_eq("en_low_idle", 32'(active), 32'd0);
    en = 1'b1;
    drain(3000);

    // Busy never rises: timeout path.
    en = 1'b0;
    frame_fix = 0;
    q_push(0, 8'h71);
    q_push(1, 8'h81);
    q_push(1, 8'h82);
    kick();
    drain(3000);

    // Reset during WAIT_DONE; next byte must come from source 0.
    en = 1'b0;
    frame_fix = 60;
    q_push(0, 8'h31);
    q_push(0, 8'h32);
    q_push(1, 8'h41);
    kick();
    wait_sig("rst_mid_busy", 1'b0, 200);
    step(5);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step(2);
    rst = 1'b1;
    wait_sig("rst_next_start", 1'b1, 200);
    check_eq("rst_next_src0", 32'(grant_id), 32'd0);
    drain(3000);

    // Randomized batches with random frame lengths, including timeouts.
    frame_fix = -1;
    for (int r = 0; r < 25; r++) begin
      int n0, n1;
      en = 1'b0;
      n0 = int'($urandom_range(0, 3));
      n1 = int'($urandom_range(0, 3));
      for (int i = 0; i < n0; i++) q_push(0, DATA_W'($urandom));
      for (int i = 0; i < n1; i++) q_push(1, DATA_W'($urandom));
      kick();
      drain(3000);
    end

    // Counter wrap: preload near the top, then send three bytes.
    en = 1'b0;
    frame_fix = 5;
    step(1);
    force dut.sent_cnt = 16'hFFFE;
    step(1);
    release dut.sent_cnt;
    m_sent = 16'hFFFE;
    q_push(0, 8'hE1);
    q_push(1, 8'hE2);
    q_push(0, 8'hE3);
    kick();
    drain(3000);
    check_eq("wrap_sent_cnt", 32'(sent_cnt), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
